// File: rtl/wb_mem_tester.sv
// ============================================================================
// Module   : wb_mem_tester
// Brief    : Wishbone master that writes a seeded pattern over a word region,
//            reads it back and reports mismatches, first bad address, timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mem_tester #(
  parameter int          N_WORDS  = 2048,
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter logic [31:0] SEED     = 32'hA5A5_5A5A,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] first_err_adr,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_ms,
  input  logic [31:0] wb_dat_sm,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic        wb_stb,
  output logic        wb_cyc,
  input  logic        wb_ack
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_TURN  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [15:0] LAST_IDX = 16'(N_WORDS - 1);
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [15:0]   idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   err_q, err_d;
  logic [31:0]   first_q, first_d;
  logic          pass_q, pass_d;
  logic          tmo_flag_q, tmo_flag_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;

  logic          stb_active;
  logic          last_beat;
  logic          tmo_expire;
  logic [15:0]   idx_inc;

  function automatic logic [31:0] pattern(input logic [15:0] i);
    return SEED ^ {~i, i};
  endfunction

  function automatic logic [31:0] word_adr(input logic [15:0] i);
    return BASE_ADR + {14'd0, i, 2'b00};
  endfunction

  assign stb_active = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign last_beat  = (idx_q == LAST_IDX);
  assign idx_inc    = idx_q + 16'd1;
  // Ack wins over an expiring counter: a late ack on the final allowed cycle is still a good beat.
  assign tmo_expire = stb_active && !wb_ack && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_WRITE;
      ST_WRITE: begin
        if (wb_ack && last_beat) state_d = ST_TURN;
        else if (tmo_expire)     state_d = ST_FIN;
      end
      ST_TURN:  state_d = ST_READ;
      ST_READ:  begin
        if (wb_ack && last_beat) state_d = ST_FIN;
        else if (tmo_expire)     state_d = ST_FIN;
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_FIN);
    wb_stb = stb_active;
    wb_cyc = stb_active || (state_q == ST_TURN);
    wb_sel = 4'hF;
  end

  always_comb begin
    idx_d      = idx_q;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    tmo_flag_d = tmo_flag_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;

    if (state_d != state_q)       tmo_d = '0;
    else if (stb_active && wb_ack) tmo_d = '0;
    else if (stb_active)           tmo_d = tmo_q + 1'b1;
    else                           tmo_d = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d      = 16'd0;
          err_d      = 16'd0;
          first_d    = 32'd0;
          pass_d     = 1'b0;
          tmo_flag_d = 1'b0;
          adr_d      = word_adr(16'd0);
          dat_d      = pattern(16'd0);
          we_d       = 1'b1;
        end
      end
      ST_WRITE: begin
        if (wb_ack) begin
          if (last_beat) begin
            idx_d = 16'd0;
            adr_d = word_adr(16'd0);
            we_d  = 1'b0;
          end else begin
            idx_d = idx_inc;
            adr_d = word_adr(idx_inc);
            dat_d = pattern(idx_inc);
          end
        end else if (tmo_expire) begin
          tmo_flag_d = 1'b1;
          we_d       = 1'b0;
        end
      end
      ST_READ: begin
        if (wb_ack) begin
          if (wb_dat_sm != pattern(idx_q)) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    first_d = adr_q;
          end
          if (!last_beat) begin
            idx_d = idx_inc;
            adr_d = word_adr(idx_inc);
          end
        end else if (tmo_expire) begin
          tmo_flag_d = 1'b1;
        end
      end
      ST_FIN: begin
        pass_d = (err_q == 16'd0) && !tmo_flag_q;
        idx_d  = 16'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      first_q    <= '0;
      pass_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      first_q    <= first_d;
      pass_q     <= pass_d;
      tmo_flag_q <= tmo_flag_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
    end
  end

  assign pass          = pass_q;
  assign timeout       = tmo_flag_q;
  assign err_count     = err_q;
  assign first_err_adr = first_q;
  assign wb_adr        = adr_q;
  assign wb_dat_ms     = dat_q;
  assign wb_we         = we_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_tester.sv
// ============================================================================
// Module   : tb_wb_mem_tester
// Brief    : Directed bench for wb_mem_tester with a configurable RAM slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_mem_tester;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_adr, wb_adr, wb_dat_ms, wb_dat_sm;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic [3:0]  wb_sel;

  wb_mem_tester #(
    .N_WORDS (N),
    .BASE_ADR(32'h0000_0000),
    .SEED    (32'h0000_0000),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .err_count    (err_count),
    .first_err_adr(first_err_adr),
    .wb_adr       (wb_adr),
    .wb_dat_ms    (wb_dat_ms),
    .wb_dat_sm    (wb_dat_sm),
    .wb_we        (wb_we),
    .wb_sel       (wb_sel),
    .wb_stb       (wb_stb),
    .wb_cyc       (wb_cyc),
    .wb_ack       (wb_ack)
  );

  always #5 clk = ~clk;

  // Slave: acks after a programmable number of waiting cycles, optional data faults.
  int          wlat = 0, rlat = 0;
  bit          corrupt_en = 1'b0, stuck0 = 1'b0, noack = 1'b0;
  logic [1:0]  corrupt_idx = 2'd0;
  int          wait_cnt = 0;
  logic [31:0] mem [4];
  logic [1:0]  sidx;

  assign sidx      = wb_adr[3:2];
  assign wb_ack    = wb_stb && !noack && (wait_cnt >= (wb_we ? wlat : rlat));
  assign wb_dat_sm = stuck0 ? 32'h0 :
                     (mem[sidx] ^ ((corrupt_en && sidx == corrupt_idx) ? 32'h1 : 32'h0));

  always @(posedge clk) begin
    if (wb_stb && !wb_ack) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
    if (wb_stb && wb_we && wb_ack) mem[sidx] <= wb_dat_ms;
  end

  // Free-running bus monitor; tests take deltas against a baseline.
  int          done_total = 0, stb_total = 0, wr_total = 0, stable_viol = 0;
  logic [31:0] wr_adr [1024];
  logic [31:0] wr_dat [1024];
  logic        prev_wait = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  always @(posedge clk) begin
    if (done)   done_total <= done_total + 1;
    if (wb_stb) stb_total  <= stb_total + 1;
    if (wb_stb && wb_we && wb_ack) begin
      wr_adr[wr_total % 1024] <= wb_adr;
      wr_dat[wr_total % 1024] <= wb_dat_ms;
      wr_total <= wr_total + 1;
    end
    if (prev_wait && wb_stb &&
        (wb_adr != prev_adr || wb_dat_ms != prev_dat || wb_we != prev_we))
      stable_viol <= stable_viol + 1;
    prev_wait <= wb_stb && !wb_ack;
    prev_adr  <= wb_adr;
    prev_dat  <= wb_dat_ms;
    prev_we   <= wb_we;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_slave(input int wl, input int rl, input bit cor, input logic [1:0] ci,
                           input bit st0, input bit na);
    wlat = wl; rlat = rl; corrupt_en = cor; corrupt_idx = ci; stuck0 = st0; noack = na;
  endtask

  // Counts cycles with the start cycle as 1; returns the count at which done is seen.
  task automatic run_sweep(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  typedef struct {
    int          wl;
    int          rl;
    bit          cor;
    logic [1:0]  ci;
    bit          st0;
    bit          na;
    bit          e_pass;
    logic [15:0] e_err;
    logic [31:0] e_first;
    bit          e_tmo;
    int          e_lat;
    int          e_stb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, s0, w0;
    logic [15:0] k16;

    //          wl rl cor ci   st0 na  pass err    first    tmo lat stb
    vecs[0] = '{0, 1, 0, 2'd0, 0, 0, 1, 16'd0, 32'h0, 0, 14, 12}; // comb write ack, 1-cycle read ack
    vecs[1] = '{0, 1, 1, 2'd2, 0, 0, 0, 16'd1, 32'h8, 0, 14, 12}; // bit 0 of word at 0x8 flipped
    vecs[2] = '{0, 0, 0, 2'd0, 1, 0, 0, 16'd4, 32'h0, 0, 10,  8}; // read data stuck at zero
    vecs[3] = '{0, 0, 0, 2'd0, 0, 1, 0, 16'd0, 32'h0, 1, 17, 16}; // slave never acks
    vecs[4] = '{3, 3, 0, 2'd0, 0, 0, 1, 16'd0, 32'h0, 0, 34, 32}; // 3-cycle ack latency
    vecs[5] = '{0, 0, 0, 2'd0, 0, 0, 1, 16'd0, 32'h0, 0, 10,  8}; // ack every cycle

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, pass, timeout, wb_cyc, wb_stb, wb_we}, 32'h0);
    check("reset_err_count", err_count, 32'h0);
    check("reset_first_err_adr", first_err_adr, 32'h0);
    check("reset_adr", wb_adr, 32'h0);
    check("reset_dat_ms", wb_dat_ms, 32'h0);
    check("reset_sel", wb_sel, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      set_slave(vecs[v].wl, vecs[v].rl, vecs[v].cor, vecs[v].ci, vecs[v].st0, vecs[v].na);
      d0 = done_total; s0 = stb_total; w0 = wr_total;
      run_sweep(lat);
      @(posedge clk); #1;
      check($sformatf("v%0d_latency", v), lat, vecs[v].e_lat);
      check($sformatf("v%0d_pass", v), pass, vecs[v].e_pass);
      check($sformatf("v%0d_err_count", v), err_count, vecs[v].e_err);
      check($sformatf("v%0d_first_err_adr", v), first_err_adr, vecs[v].e_first);
      check($sformatf("v%0d_timeout", v), timeout, vecs[v].e_tmo);
      check($sformatf("v%0d_done_pulses", v), done_total - d0, 1);
      check($sformatf("v%0d_stb_cycles", v), stb_total - s0, vecs[v].e_stb);
      check($sformatf("v%0d_idle_bus", v), {wb_cyc, wb_stb, busy}, 32'h0);
      if (!vecs[v].na) begin
        for (int k = 0; k < N; k++) begin
          k16 = 16'(k);
          check($sformatf("v%0d_wr%0d_adr", v, k), wr_adr[(w0 + k) % 1024], 32'(4 * k));
          check($sformatf("v%0d_wr%0d_dat", v, k), wr_dat[(w0 + k) % 1024], {~k16, k16});
        end
      end else begin
        check($sformatf("v%0d_no_writes", v), wr_total - w0, 0);
      end
    end
    check("bus_stable_while_waiting", stable_viol, 0);

    // Results must hold in IDLE while nothing is started.
    repeat (3) @(posedge clk);
    #1;
    check("hold_pass", pass, 1);

    // Reset asserted mid-read: bus drops without waiting for a clock edge.
    @(negedge clk);
    set_slave(0, 1, 0, 2'd0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !(wb_stb && !wb_we); k++) @(negedge clk);
    check("reached_read", {wb_stb, wb_we}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {busy, done, pass, timeout, wb_cyc, wb_stb, wb_we}, 32'h0);
    check("async_reset_adr", wb_adr, 32'h0);
    check("async_reset_dat", wb_dat_ms, 32'h0);
    d0 = done_total;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_reset", done_total - d0, 0);
    run_sweep(lat);
    @(posedge clk); #1;
    check("post_reset_latency", lat, 14);
    check("post_reset_pass", pass, 1);

    // start while busy is ignored: no restart, error count keeps accumulating.
    @(negedge clk);
    set_slave(0, 0, 0, 2'd0, 1, 0);
    d0 = done_total; s0 = stb_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && err_count != 16'd2; k++) @(negedge clk);
    check("busy_err_reached", err_count, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_no_clear", err_count, 3);
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    @(negedge clk);
    check("busy_start_err_final", err_count, 4);
    check("busy_start_single_done", done_total - d0, 1);
    check("busy_start_no_restart", stb_total - s0, 8);
    check("busy_start_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
